bcd_calc_ctrl: RTL and testbench

Parametrised keypad calculator controller: collects two unsigned BCD operands of `NDIG` digits from a debounced keypad decoder and applies add or subtract. It computes the result digit-serially with a BCD adder, then presents operand or result to the multiplexed seven-segment driver. It sits between the keypad scanner and the display driver. It adds subtraction, sign and overflow flags, operand-length limiting, result chaining and clear to the existing fixed 4-digit add-only datapath.

---
 rtl/bcd_calc_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_bcd_calc_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_calc_ctrl.sv
// Keypad calculator controller: collects two NDIG-digit BCD operands, then adds or
// subtracts them one digit per cycle and drives the seven-segment display value.
module bcd_calc_ctrl #(
    parameter int NDIG = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_valid,
    input  logic [3:0]        i_key_code,
    output logic [4*NDIG-1:0] o_disp_bcd,
    output logic              o_neg,
    output logic              o_ovf,
    output logic              o_busy,
    output logic              o_done
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NDIG);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_CALC    = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_a, r_b, r_res, r_disp;
    logic [W-1:0]  w_a_nxt, w_b_nxt, w_res_nxt, w_disp_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic          r_op, r_c, r_swap, r_neg, r_ovf, r_busy, r_done;
    logic          w_op_nxt, w_c_nxt, w_swap_nxt, w_neg_nxt, w_ovf_nxt, w_done_nxt;

    logic          w_is_digit, w_is_op, w_is_eq, w_is_clr;
    logic [3:0]    w_x, w_y, w_dig;
    logic [4:0]    w_sum, w_dif;
    logic          w_cout;

    assign w_is_digit = i_key_valid && (i_key_code <= 4'd9);
    assign w_is_op    = i_key_valid && ((i_key_code == 4'hA) || (i_key_code == 4'hB));
    assign w_is_eq    = i_key_valid && (i_key_code == 4'hE);
    assign w_is_clr   = i_key_valid && (i_key_code == 4'hC);

    // r_swap selects b-a when a<b so the subtraction never goes negative
    assign w_x   = r_swap ? r_b[{r_idx, 2'b00} +: 4] : r_a[{r_idx, 2'b00} +: 4];
    assign w_y   = r_swap ? r_a[{r_idx, 2'b00} +: 4] : r_b[{r_idx, 2'b00} +: 4];
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'd0, r_c};
    assign w_dif = {1'b0, w_x} - {1'b0, w_y} - {4'd0, r_c};

    // State register and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_ENTER_A;
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_res   <= {W{1'b0}};
            r_disp  <= {W{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_idx   <= {IW{1'b0}};
            r_op    <= 1'b0;
            r_c     <= 1'b0;
            r_swap  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_res   <= w_res_nxt;
            r_disp  <= w_disp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_op    <= w_op_nxt;
            r_c     <= w_c_nxt;
            r_swap  <= w_swap_nxt;
            r_neg   <= (w_state_nxt == ST_SHOW) ? w_neg_nxt : 1'b0;
            r_ovf   <= (w_state_nxt == ST_SHOW) ? w_ovf_nxt : 1'b0;
            r_busy  <= (w_state_nxt == ST_CALC);
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, datapath and display selection
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_op_nxt    = r_op;
        w_c_nxt     = r_c;
        w_swap_nxt  = r_swap;
        w_neg_nxt   = r_neg;
        w_ovf_nxt   = r_ovf;
        w_done_nxt  = 1'b0;
        w_disp_nxt  = r_disp;
        w_dig       = 4'd0;
        w_cout      = 1'b0;

        if (r_op) begin
            if (w_dif[4]) begin
                w_dig  = w_dif[3:0] + 4'd10;
                w_cout = 1'b1;
            end else begin
                w_dig  = w_dif[3:0];
                w_cout = 1'b0;
            end
        end else begin
            if (w_sum > 5'd9) begin
                w_dig  = w_sum[3:0] - 4'd10;
                w_cout = 1'b1;
            end else begin
                w_dig  = w_sum[3:0];
                w_cout = 1'b0;
            end
        end

        if (w_is_clr) begin
            w_state_nxt = ST_ENTER_A;
            w_a_nxt     = {W{1'b0}};
            w_b_nxt     = {W{1'b0}};
            w_res_nxt   = {W{1'b0}};
            w_cnt_nxt   = {CW{1'b0}};
            w_idx_nxt   = {IW{1'b0}};
            w_op_nxt    = 1'b0;
            w_c_nxt     = 1'b0;
            w_swap_nxt  = 1'b0;
            w_neg_nxt   = 1'b0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_ENTER_A: begin
                    if (w_is_digit && (r_cnt < CNT_MAX)) begin
                        w_a_nxt      = r_a << 4;
                        w_a_nxt[3:0] = i_key_code;
                        w_cnt_nxt    = r_cnt + CNT_ONE;
                    end else if (w_is_op) begin
                        w_op_nxt    = i_key_code[0];
                        w_b_nxt     = {W{1'b0}};
                        w_cnt_nxt   = {CW{1'b0}};
                        w_state_nxt = ST_ENTER_B;
                    end else begin
                        w_state_nxt = ST_ENTER_A;
                    end
                end
                ST_ENTER_B: begin
                    if (w_is_digit && (r_cnt < CNT_MAX)) begin
                        w_b_nxt      = r_b << 4;
                        w_b_nxt[3:0] = i_key_code;
                        w_cnt_nxt    = r_cnt + CNT_ONE;
                    end else if (w_is_op) begin
                        w_op_nxt = i_key_code[0];
                    end else if (w_is_eq) begin
                        w_idx_nxt   = {IW{1'b0}};
                        w_c_nxt     = 1'b0;
                        w_swap_nxt  = r_op && (r_a < r_b);
                        w_state_nxt = ST_CALC;
                    end else begin
                        w_state_nxt = ST_ENTER_B;
                    end
                end
                ST_CALC: begin
                    w_res_nxt[{r_idx, 2'b00} +: 4] = w_dig;
                    w_c_nxt   = w_cout;
                    w_idx_nxt = r_idx + IDX_ONE;
                    if (r_idx == IDX_LAST) begin
                        w_ovf_nxt   = ~r_op & w_cout;
                        w_neg_nxt   = r_op & r_swap;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_state_nxt = ST_CALC;
                    end
                end
                ST_SHOW: begin
                    if (w_is_digit) begin
                        w_a_nxt      = {W{1'b0}};
                        w_a_nxt[3:0] = i_key_code;
                        w_cnt_nxt    = CNT_ONE;
                        w_state_nxt  = ST_ENTER_A;
                    end else if (w_is_op && !r_neg && !r_ovf) begin
                        // chained result is the full a operand; the counter then tracks b entry
                        w_a_nxt     = r_res;
                        w_b_nxt     = {W{1'b0}};
                        w_cnt_nxt   = {CW{1'b0}};
                        w_op_nxt    = i_key_code[0];
                        w_state_nxt = ST_ENTER_B;
                    end else begin
                        w_state_nxt = ST_SHOW;
                    end
                end
                default: begin
                    w_state_nxt = ST_ENTER_A;
                end
            endcase
        end

        case (w_state_nxt)
            ST_ENTER_A: w_disp_nxt = w_a_nxt;
            ST_ENTER_B: w_disp_nxt = w_b_nxt;
            ST_CALC:    w_disp_nxt = r_disp;
            ST_SHOW:    w_disp_nxt = w_res_nxt;
            default:    w_disp_nxt = r_disp;
        endcase
    end

    assign o_disp_bcd = r_disp;
    assign o_neg      = r_neg;
    assign o_ovf      = r_ovf;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// Bench for bcd_calc_ctrl (NDIG=4): directed vector table followed by random key
// streams checked against a decimal-arithmetic reference model.
module tb_bcd_calc_ctrl;

    localparam int NDIG = 4;
    localparam int MAXV = 10000;

    logic        clk = 1'b0;
    logic        rst, kv;
    logic [3:0]  kc;
    logic [15:0] disp;
    logic        neg, ovf, busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_calc_ctrl #(.NDIG(NDIG)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_key_valid(kv),
        .i_key_code (kc),
        .o_disp_bcd (disp),
        .o_neg      (neg),
        .o_ovf      (ovf),
        .o_busy     (busy),
        .o_done     (done)
    );

    typedef struct {
        logic        r;
        logic        k;
        logic [3:0]  c;
        logic [15:0] d;
        logic        n, o, b, dn;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic k, input logic [3:0] c, input logic [15:0] d,
                     input logic n, input logic o, input logic b, input logic dn);
        vec_t t;
        t.r = r; t.k = k; t.c = c; t.d = d; t.n = n; t.o = o; t.b = b; t.dn = dn;
        vecs.push_back(t);
    endtask

    task automatic key(input logic [3:0] c, input logic [15:0] d);
        v(1'b0, 1'b1, c, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic k, input logic [3:0] c);
        rst = r; kv = k; kc = c;
        @(posedge clk);
        #1;
    endtask

    // reference model: operands and result kept as plain decimal integers
    int   m_mode, m_a, m_b, m_res, m_cnt, m_left, m_op;
    bit   m_neg, m_ovf, m_done;
    int   p_res;
    bit   p_neg, p_ovf;
    logic [15:0] m_disp;

    function automatic logic [15:0] to_bcd(input int val);
        logic [15:0] r;
        int x;
        x = val;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_step(input bit r, input bit k, input logic [3:0] c);
        bit dig, opk, eq;
        dig = k && (c <= 4'd9);
        opk = k && (c == 4'hA || c == 4'hB);
        eq  = k && (c == 4'hE);
        m_done = 1'b0;
        if (r || (k && c == 4'hC)) begin
            m_mode = 0; m_a = 0; m_b = 0; m_res = 0; m_cnt = 0; m_op = 0;
            m_neg = 1'b0; m_ovf = 1'b0; m_disp = 16'h0000;
            return;
        end
        case (m_mode)
            0: begin
                if (dig && m_cnt < NDIG) begin
                    m_a = (m_a * 10 + int'(c)) % MAXV; m_cnt++;
                end else if (opk) begin
                    m_op = (c == 4'hB) ? 1 : 0; m_b = 0; m_cnt = 0; m_mode = 1;
                end
            end
            1: begin
                if (dig && m_cnt < NDIG) begin
                    m_b = (m_b * 10 + int'(c)) % MAXV; m_cnt++;
                end else if (opk) begin
                    m_op = (c == 4'hB) ? 1 : 0;
                end else if (eq) begin
                    m_mode = 2; m_left = NDIG;
                    if (m_op == 0) begin
                        p_res = (m_a + m_b) % MAXV; p_ovf = (m_a + m_b) >= MAXV; p_neg = 1'b0;
                    end else if (m_a >= m_b) begin
                        p_res = m_a - m_b; p_neg = 1'b0; p_ovf = 1'b0;
                    end else begin
                        p_res = m_b - m_a; p_neg = 1'b1; p_ovf = 1'b0;
                    end
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 3; m_res = p_res; m_neg = p_neg; m_ovf = p_ovf; m_done = 1'b1;
                end
            end
            default: begin
                if (dig) begin
                    m_a = int'(c); m_cnt = 1; m_mode = 0;
                end else if (opk && !m_neg && !m_ovf) begin
                    m_a = m_res; m_b = 0; m_cnt = 0; m_op = (c == 4'hB) ? 1 : 0; m_mode = 1;
                end
            end
        endcase
        if (m_mode == 0) m_disp = to_bcd(m_a);
        else if (m_mode == 1) m_disp = to_bcd(m_b);
        else if (m_mode == 3) m_disp = to_bcd(m_res);
    endtask

    initial begin
        logic r, k;
        logic [3:0] c;
        int sel;
        rst = 1'b1; kv = 1'b0; kc = 4'h0;

        v(1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // five digits into a four-digit operand
        key(4'd1, 16'h0001); key(4'd2, 16'h0012); key(4'd3, 16'h0123);
        key(4'd4, 16'h1234); key(4'd5, 16'h1234); key(4'hC, 16'h0000);
        // 1234 + 8766 overflows to 0000
        key(4'd1, 16'h0001); key(4'd2, 16'h0012); key(4'd3, 16'h0123); key(4'd4, 16'h1234);
        key(4'hA, 16'h0000); key(4'd8, 16'h0008); key(4'd7, 16'h0087); key(4'd6, 16'h0876);
        key(4'd6, 16'h8766);
        v(1'b0, 1'b1, 4'hE, 16'h8766, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) v(1'b0, 1'b0, 4'h0, 16'h8766, 1'b0, 1'b0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        v(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        // 25 - 100 = -75, then operator and equals dropped
        key(4'd2, 16'h0002); key(4'd5, 16'h0025); key(4'hB, 16'h0000);
        key(4'd1, 16'h0001); key(4'd0, 16'h0010); key(4'd0, 16'h0100);
        v(1'b0, 1'b1, 4'hE, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) v(1'b0, 1'b0, 4'h0, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 4'h0, 16'h0075, 1'b1, 1'b0, 1'b0, 1'b1);
        v(1'b0, 1'b1, 4'hA, 16'h0075, 1'b1, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b1, 4'hE, 16'h0075, 1'b1, 1'b0, 1'b0, 1'b0);
        // 999 + 1, then chained + 5
        key(4'd9, 16'h0009); key(4'd9, 16'h0099); key(4'd9, 16'h0999);
        key(4'hA, 16'h0000); key(4'd1, 16'h0001);
        v(1'b0, 1'b1, 4'hE, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) v(1'b0, 1'b0, 4'h0, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 4'h0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        key(4'hA, 16'h0000); key(4'd5, 16'h0005);
        v(1'b0, 1'b1, 4'hE, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) v(1'b0, 1'b0, 4'h0, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 4'h0, 16'h1005, 1'b0, 1'b0, 1'b0, 1'b1);
        // 42 + 7, clear in the second CALC cycle
        key(4'd4, 16'h0004); key(4'd2, 16'h0042); key(4'hA, 16'h0000); key(4'd7, 16'h0007);
        v(1'b0, 1'b1, 4'hE, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0);
        v(1'b0, 1'b0, 4'h0, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0);
        key(4'hC, 16'h0000);
        for (int i = 0; i < 5; i++) v(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // reset with a simultaneous digit during b entry
        key(4'd1, 16'h0001); key(4'hA, 16'h0000); key(4'd3, 16'h0003);
        v(1'b1, 1'b1, 4'd9, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        v(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        key(4'd5, 16'h0005); key(4'hE, 16'h0005); key(4'hD, 16'h0005); key(4'hF, 16'h0005);
        key(4'hA, 16'h0000); key(4'd5, 16'h0005);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].k, vecs[i].c);
            check($sformatf("vec%0d disp", i), disp, vecs[i].d);
            check($sformatf("vec%0d neg", i), {15'd0, neg}, {15'd0, vecs[i].n});
            check($sformatf("vec%0d ovf", i), {15'd0, ovf}, {15'd0, vecs[i].o});
            check($sformatf("vec%0d busy", i), {15'd0, busy}, {15'd0, vecs[i].b});
            check($sformatf("vec%0d done", i), {15'd0, done}, {15'd0, vecs[i].dn});
        end

        drive(1'b1, 1'b0, 4'h0);
        model_step(1'b1, 1'b0, 4'h0);
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            k = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 99);
            if (sel < 60)      c = 4'($urandom_range(0, 9));
            else if (sel < 75) c = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hB;
            else if (sel < 91) c = 4'hE;
            else if (sel < 93) c = 4'hC;
            else if (sel < 96) c = 4'hD;
            else               c = 4'hF;
            drive(r, k, c);
            model_step(r, k, c);
            check($sformatf("rnd%0d disp", n), disp, m_disp);
            check($sformatf("rnd%0d neg", n), {15'd0, neg}, {15'd0, (m_mode == 3) && m_neg});
            check($sformatf("rnd%0d ovf", n), {15'd0, ovf}, {15'd0, (m_mode == 3) && m_ovf});
            check($sformatf("rnd%0d busy", n), {15'd0, busy}, {15'd0, m_mode == 2});
            check($sformatf("rnd%0d done", n), {15'd0, done}, {15'd0, m_done});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
